sdf_feedback_delay: RTL and testbench
=====================================

SDF_FEEDBACK_DELAY -- requirements
Module: sdf_feedback_delay

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width per real/imag component.
REQ-002 SHALL have parameter DEPTH, default 8, feedback delay length in samples; legal values 1, 2, 4, 8.
REQ-003 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Valid_In, input, 1, qualifies Data_In_* and Fb_In_* this cycle.
REQ-006 SHALL have ports Data_In_Re / Data_In_Im, input, WIDTH signed, new stage input sample.
REQ-007 SHALL have ports Fb_In_Re / Fb_In_Im, input, WIDTH signed, butterfly difference result fed back.
REQ-008 SHALL have ports Delay_Out_Re / Delay_Out_Im, output, WIDTH signed, oldest buffered sample.
REQ-009 SHALL have port Selection, output, 1; 1 = butterfly phase, 0 = fill phase; drives the stage output mux.
REQ-010 SHALL have port Delay_Valid, output, 1, buffer holds DEPTH samples written since reset.
REQ-011 SHALL have port Frame_Start, output, 1, one-cycle pulse marking the first sample of a 2*DEPTH frame.

Function
REQ-012 SHALL hold a circular buffer of DEPTH complex entries with write pointer Wr_Ptr (log2 DEPTH bits; 1 bit when DEPTH=1).
REQ-013 SHALL hold phase counter Cnt, 0..2*DEPTH-1, incremented by 1 on each cycle with Valid_In=1, wrapping 2*DEPTH-1 -> 0.
REQ-014 SHALL drive Selection = 1 when Cnt >= DEPTH, else 0, decoded combinationally from the registered Cnt.
REQ-015 SHALL drive Delay_Out_* combinationally from the entry at Wr_Ptr, the sample written exactly DEPTH valid cycles earlier.
REQ-016 SHALL, on Valid_In=1, write Data_In_* when Selection=0 or Fb_In_* when Selection=1 into entry Wr_Ptr, then advance Wr_Ptr modulo DEPTH.
REQ-017 SHALL, on Valid_In=0, hold Cnt, Wr_Ptr, buffer, Delay_Valid and all outputs unchanged (stall).
REQ-018 SHALL keep a fill counter that saturates at DEPTH; Delay_Valid = 1 once DEPTH valid writes have completed, and stays 1 until reset.
REQ-019 SHALL drive Frame_Start = Valid_In AND (Cnt == 0).
REQ-020 SHALL apply no arithmetic; data passes bit-exact, with no rounding, saturation or width change.
REQ-021 SHALL, for a read and write of the same entry in one cycle, present the old entry on Delay_Out_* that cycle and the new value DEPTH valid cycles later.

Reset
REQ-022 SHALL, while RST=0, asynchronously force Cnt=0, Wr_Ptr=0, fill counter=0 and all buffer entries=0.
REQ-023 SHALL therefore show Selection=0, Delay_Valid=0, Frame_Start=0 and Delay_Out_*=0 during reset.
REQ-024 SHALL, on a mid-frame reset, discard the partial frame; the first Valid_In after release is treated as Cnt=0.

Configuration
REQ-025 SHALL recognise macro SDF_DELAY_CLEAR_EN.
REQ-026 SHALL, with SDF_DELAY_CLEAR_EN defined, add input port Clear (1 bit); Clear=1 at a clock edge synchronously performs the REQ-022 reset actions.
REQ-027 SHALL give Clear priority over Valid_In in the same cycle, so no write and no count occur.
REQ-028 SHALL, with SDF_DELAY_CLEAR_EN undefined, omit the Clear port and its logic entirely.

Verification
REQ-029 SHALL cover: DEPTH=4; reset, then 8 continuous valid samples Data_In_Re=1..8 with Fb_In_Re=100+n -> Selection 0,0,0,0,1,1,1,1; Delay_Out_Re 0,0,0,0,1,2,3,4; Frame_Start only on sample 1.
REQ-030 SHALL cover: DEPTH=4; second frame after REQ-029 -> Delay_Out_Re over cycles 9..12 equals the Fb_In_Re values written in cycles 5..8 (105..108); Delay_Valid=1 from cycle 5 onward.
REQ-031 SHALL cover: DEPTH=4; Valid_In toggled 1,0,1,0 across a frame -> Cnt, Selection and Delay_Out_* frozen during every Valid_In=0 cycle; same data sequence as REQ-029.
REQ-032 SHALL cover: DEPTH=8; RST asserted after 5 valid samples -> all outputs 0 immediately; after release, the next sample gives Frame_Start=1 and Selection=0.
REQ-033 SHALL cover: DEPTH=1; alternating samples -> Selection toggles 0,1,0,1 and Delay_Out equals the previous cycle's written value.
REQ-034 SHALL cover: with SDF_DELAY_CLEAR_EN defined, Clear=1 together with Valid_In=1 at Cnt=6 -> Cnt=0, Delay_Valid=0, no write.

Source files
------------

// File: rtl/sdf_feedback_delay.sv
// -----------------------------------------------------------------------------
// sdf_feedback_delay
//
// Feedback delay line for one stage of a single-path delay-feedback (SDF) FFT.
// A circular buffer of DEPTH complex samples is written once per valid cycle.
// In the fill phase the new stage input is stored. In the butterfly phase the
// butterfly difference result is stored and fed back. The entry under the
// write pointer is always the sample written DEPTH valid cycles earlier. It is
// presented on Delay_Out_* in the same cycle that the entry is overwritten.
// Data passes through bit-exact.
//
// Parameters
//   WIDTH        bits per real / imaginary component
//   DEPTH        feedback delay in samples (1, 2, 4 or 8)
//
// Ports
//   CLK          clock; all state changes on the rising edge
//   RST          asynchronous active-low reset (clears counters and buffer)
//   Clear        synchronous clear; present only with SDF_DELAY_CLEAR_EN.
//                It takes priority over Valid_In.
//   Valid_In     qualifies Data_In_* / Fb_In_*; when low the block stalls
//   Data_In_Re/Im  new stage input sample (written in the fill phase)
//   Fb_In_Re/Im    butterfly difference (written in the butterfly phase)
//   Delay_Out_Re/Im  oldest buffered sample (combinational from the buffer)
//   Selection    1 = butterfly phase, 0 = fill phase
//   Delay_Valid  buffer holds DEPTH samples written since reset / clear
//   Frame_Start  first valid sample of each 2*DEPTH-sample frame
//
// Build option
//   SDF_DELAY_CLEAR_EN  when defined, adds the Clear input and its logic
// -----------------------------------------------------------------------------
module sdf_feedback_delay #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
`ifdef SDF_DELAY_CLEAR_EN
  input  logic                    Clear,
`endif
  input  logic                    Valid_In,
  input  logic signed [WIDTH-1:0] Data_In_Re,
  input  logic signed [WIDTH-1:0] Data_In_Im,
  input  logic signed [WIDTH-1:0] Fb_In_Re,
  input  logic signed [WIDTH-1:0] Fb_In_Im,
  output logic signed [WIDTH-1:0] Delay_Out_Re,
  output logic signed [WIDTH-1:0] Delay_Out_Im,
  output logic                    Selection,
  output logic                    Delay_Valid,
  output logic                    Frame_Start
);

  // A single-entry buffer still carries a 1-bit pointer (always 0).
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(2 * DEPTH);
  localparam int FILL_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_nxt_s;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        wr_ptr_nxt_s;
  logic [FILL_W-1:0]       fill_r;
  logic [FILL_W-1:0]       fill_nxt_s;
  logic                    wr_en_s;
  logic                    clear_s;
  logic                    sel_s;
  logic signed [WIDTH-1:0] wr_re_s;
  logic signed [WIDTH-1:0] wr_im_s;
  logic signed [WIDTH-1:0] rd_re_s;
  logic signed [WIDTH-1:0] rd_im_s;
  logic signed [WIDTH-1:0] mem_re_r [DEPTH];
  logic signed [WIDTH-1:0] mem_im_r [DEPTH];

`ifdef SDF_DELAY_CLEAR_EN
  assign clear_s = Clear;
`else
  // Tied off so the clear branches below fold away in the default build.
  assign clear_s = 1'b0;
`endif

  // Phase decode from the registered counter: the second half of a frame is the butterfly phase.
  assign sel_s = (cnt_r >= CNT_W'(DEPTH));

  // Select what gets written this cycle: the new input while filling, the feedback while in butterfly.
  always_comb begin
    wr_re_s = Data_In_Re;
    wr_im_s = Data_In_Im;
    if (sel_s) begin
      wr_re_s = Fb_In_Re;
      wr_im_s = Fb_In_Im;
    end else begin
      wr_re_s = Data_In_Re;
      wr_im_s = Data_In_Im;
    end
  end

  // Next-state for phase counter, write pointer and fill counter; clear beats valid, no valid means stall.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    wr_ptr_nxt_s = wr_ptr_r;
    fill_nxt_s   = fill_r;
    wr_en_s      = 1'b0;
    if (clear_s) begin
      cnt_nxt_s    = {CNT_W{1'b0}};
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      fill_nxt_s   = {FILL_W{1'b0}};
      wr_en_s      = 1'b0;
    end else if (Valid_In) begin
      wr_en_s = 1'b1;
      if (cnt_r == CNT_W'(2 * DEPTH - 1)) begin
        cnt_nxt_s = {CNT_W{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
      if (wr_ptr_r == PTR_W'(DEPTH - 1)) begin
        wr_ptr_nxt_s = {PTR_W{1'b0}};
      end else begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end
      // Saturates at DEPTH so Delay_Valid stays high until reset or clear.
      if (fill_r != FILL_W'(DEPTH)) begin
        fill_nxt_s = fill_r + FILL_W'(1);
      end else begin
        fill_nxt_s = fill_r;
      end
    end else begin
      cnt_nxt_s    = cnt_r;
      wr_ptr_nxt_s = wr_ptr_r;
      fill_nxt_s   = fill_r;
      wr_en_s      = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r    <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      fill_r   <= {FILL_W{1'b0}};
    end else begin
      cnt_r    <= cnt_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      fill_r   <= fill_nxt_s;
    end
  end

  // Circular buffer storage; every entry is zeroed by reset and by clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_re_r[i] <= {WIDTH{1'b0}};
        mem_im_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clear_s) begin
          mem_re_r[i] <= {WIDTH{1'b0}};
          mem_im_r[i] <= {WIDTH{1'b0}};
        end else if (wr_en_s && (wr_ptr_r == PTR_W'(i))) begin
          mem_re_r[i] <= wr_re_s;
          mem_im_r[i] <= wr_im_s;
        end else begin
          mem_re_r[i] <= mem_re_r[i];
          mem_im_r[i] <= mem_im_r[i];
        end
      end
    end
  end

  // Read the entry about to be overwritten; the written value only appears DEPTH valid cycles later.
  if (DEPTH == 1) begin : g_rd_single
    assign rd_re_s = mem_re_r[0];
    assign rd_im_s = mem_im_r[0];
  end else begin : g_rd_multi
    assign rd_re_s = mem_re_r[wr_ptr_r];
    assign rd_im_s = mem_im_r[wr_ptr_r];
  end

  assign Delay_Out_Re = rd_re_s;
  assign Delay_Out_Im = rd_im_s;
  assign Selection    = sel_s;
  assign Delay_Valid  = (fill_r == FILL_W'(DEPTH));
  // Gated by RST so no pulse appears while reset is held with Valid_In high.
  assign Frame_Start  = Valid_In & RST & (cnt_r == {CNT_W{1'b0}});

endmodule

// File: tb/tb_sdf_feedback_delay.sv
// -----------------------------------------------------------------------------
// Testbench for sdf_feedback_delay. It runs three instances (DEPTH 4, 8 and 1)
// side by side on shared stimulus. A reference model checks every instance on
// every cycle. The model keeps the history of written values and treats the
// delay output as "the value written DEPTH valid cycles ago". A DEPTH=4 vector
// table and hand sequences cover the named corner cases.
// -----------------------------------------------------------------------------
module tb_sdf_feedback_delay;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic clear = 1'b0;
  logic signed [15:0] d_re = 16'sd0, d_im = 16'sd0, f_re = 16'sd0, f_im = 16'sd0;

  logic signed [15:0] o_re [3];
  logic signed [15:0] o_im [3];
  logic sel [3];
  logic dv  [3];
  logic fs  [3];

  int total = 0;
  int bad   = 0;

  // model state: valid writes since reset/clear and history of written values
  int n [3];
  logic [15:0] h_re [3][4096];
  logic [15:0] h_im [3][4096];

  always #5 clk = ~clk;

  sdf_feedback_delay #(.WIDTH(16), .DEPTH(4)) u_d4 (
    .CLK(clk), .RST(rst_n),
`ifdef SDF_DELAY_CLEAR_EN
    .Clear(clear),
`endif
    .Valid_In(valid), .Data_In_Re(d_re), .Data_In_Im(d_im),
    .Fb_In_Re(f_re), .Fb_In_Im(f_im),
    .Delay_Out_Re(o_re[0]), .Delay_Out_Im(o_im[0]),
    .Selection(sel[0]), .Delay_Valid(dv[0]), .Frame_Start(fs[0]));

  sdf_feedback_delay #(.WIDTH(16), .DEPTH(8)) u_d8 (
    .CLK(clk), .RST(rst_n),
`ifdef SDF_DELAY_CLEAR_EN
    .Clear(clear),
`endif
    .Valid_In(valid), .Data_In_Re(d_re), .Data_In_Im(d_im),
    .Fb_In_Re(f_re), .Fb_In_Im(f_im),
    .Delay_Out_Re(o_re[1]), .Delay_Out_Im(o_im[1]),
    .Selection(sel[1]), .Delay_Valid(dv[1]), .Frame_Start(fs[1]));

  sdf_feedback_delay #(.WIDTH(16), .DEPTH(1)) u_d1 (
    .CLK(clk), .RST(rst_n),
`ifdef SDF_DELAY_CLEAR_EN
    .Clear(clear),
`endif
    .Valid_In(valid), .Data_In_Re(d_re), .Data_In_Im(d_im),
    .Fb_In_Re(f_re), .Fb_In_Im(f_im),
    .Delay_Out_Re(o_re[2]), .Delay_Out_Im(o_im[2]),
    .Selection(sel[2]), .Delay_Valid(dv[2]), .Frame_Start(fs[2]));

  typedef struct {
    bit rst_first;
    bit v;
    int d;
    int f;
    bit e_sel;
    int e_out;
    bit e_fs;
    bit e_dv;
  } vec_t;

  vec_t tab [28];

  function automatic int dep(input int k);
    case (k)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic vec_t mk(input bit r, input bit v, input int d, input int f,
                              input bit s, input int o, input bit fsx, input bit dvx);
    vec_t t;
    t.rst_first = r; t.v = v; t.d = d; t.f = f;
    t.e_sel = s; t.e_out = o; t.e_fs = fsx; t.e_dv = dvx;
    return t;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_sel(input int k);
    return (n[k] % (2 * dep(k))) >= dep(k);
  endfunction

  // compare every instance against the model for the inputs currently applied
  task automatic model_check();
    for (int k = 0; k < 3; k++) begin
      int dd;
      logic [15:0] er, ei;
      dd = dep(k);
      er = (n[k] >= dd) ? h_re[k][(n[k] - dd) & 4095] : 16'h0000;
      ei = (n[k] >= dd) ? h_im[k][(n[k] - dd) & 4095] : 16'h0000;
      chk($sformatf("sel_d%0d", dd), 16'(sel[k]), 16'(m_sel(k)));
      chk($sformatf("out_re_d%0d", dd), o_re[k], er);
      chk($sformatf("out_im_d%0d", dd), o_im[k], ei);
      chk($sformatf("dvalid_d%0d", dd), 16'(dv[k]), 16'(n[k] >= dd));
      chk($sformatf("fstart_d%0d", dd), 16'(fs[k]),
          16'(valid && rst_n && ((n[k] % (2 * dd)) == 0)));
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] dre, input logic [15:0] dim,
                       input logic [15:0] fre, input logic [15:0] fim, input bit clr);
    @(negedge clk);
    valid = v; d_re = dre; d_im = dim; f_re = fre; f_im = fim; clear = clr;
    #1;
    model_check();
  endtask

  // advance the model across the rising edge
  task automatic commit();
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (clear) begin
          n[k] = 0;
        end else if (valid) begin
          h_re[k][n[k] & 4095] = m_sel(k) ? f_re : d_re;
          h_im[k][n[k] & 4095] = m_sel(k) ? f_im : d_im;
          n[k]++;
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [15:0] dre, input logic [15:0] dim,
                     input logic [15:0] fre, input logic [15:0] fim, input bit clr);
    drive(v, dre, dim, fre, fim, clr);
    commit();
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_out_re_d%0d", tag, dep(k)), o_re[k], 16'h0000);
      chk($sformatf("%s_out_im_d%0d", tag, dep(k)), o_im[k], 16'h0000);
      chk($sformatf("%s_sel_d%0d", tag, dep(k)), 16'(sel[k]), 16'h0000);
      chk($sformatf("%s_dvalid_d%0d", tag, dep(k)), 16'(dv[k]), 16'h0000);
      chk($sformatf("%s_fstart_d%0d", tag, dep(k)), 16'(fs[k]), 16'h0000);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b1; clear = 1'b0;
    #1;
    check_all_zero("rst");
    for (int k = 0; k < 3; k++) n[k] = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    valid = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) n[k] = 0;

    // DEPTH=4: two continuous frames, then a frame with Valid_In toggled 1,0,1,0
    tab[0]  = mk(1, 1, 1, 101, 0, 0,   1, 0);
    tab[1]  = mk(0, 1, 2, 102, 0, 0,   0, 0);
    tab[2]  = mk(0, 1, 3, 103, 0, 0,   0, 0);
    tab[3]  = mk(0, 1, 4, 104, 0, 0,   0, 0);
    tab[4]  = mk(0, 1, 5, 105, 1, 1,   0, 1);
    tab[5]  = mk(0, 1, 6, 106, 1, 2,   0, 1);
    tab[6]  = mk(0, 1, 7, 107, 1, 3,   0, 1);
    tab[7]  = mk(0, 1, 8, 108, 1, 4,   0, 1);
    tab[8]  = mk(0, 1, 9, 109, 0, 105, 1, 1);
    tab[9]  = mk(0, 1, 10, 110, 0, 106, 0, 1);
    tab[10] = mk(0, 1, 11, 111, 0, 107, 0, 1);
    tab[11] = mk(0, 1, 12, 112, 0, 108, 0, 1);
    tab[12] = mk(1, 1, 1, 101, 0, 0,   1, 0);
    tab[13] = mk(0, 0, 77, 177, 0, 0,  0, 0);
    tab[14] = mk(0, 1, 2, 102, 0, 0,   0, 0);
    tab[15] = mk(0, 0, 77, 177, 0, 0,  0, 0);
    tab[16] = mk(0, 1, 3, 103, 0, 0,   0, 0);
    tab[17] = mk(0, 0, 77, 177, 0, 0,  0, 0);
    tab[18] = mk(0, 1, 4, 104, 0, 0,   0, 0);
    tab[19] = mk(0, 0, 77, 177, 1, 1,  0, 1);
    tab[20] = mk(0, 1, 5, 105, 1, 1,   0, 1);
    tab[21] = mk(0, 0, 77, 177, 1, 2,  0, 1);
    tab[22] = mk(0, 1, 6, 106, 1, 2,   0, 1);
    tab[23] = mk(0, 0, 77, 177, 1, 3,  0, 1);
    tab[24] = mk(0, 1, 7, 107, 1, 3,   0, 1);
    tab[25] = mk(0, 0, 77, 177, 1, 4,  0, 1);
    tab[26] = mk(0, 1, 8, 108, 1, 4,   0, 1);
    tab[27] = mk(0, 0, 77, 177, 0, 105, 0, 1);

    for (int i = 0; i < 28; i++) begin
      if (tab[i].rst_first) do_reset();
      drive(tab[i].v, 16'(tab[i].d), 16'(tab[i].d + 1000),
            16'(tab[i].f), 16'(tab[i].f + 1000), 1'b0);
      chk($sformatf("tab%0d_sel", i), 16'(sel[0]), 16'(tab[i].e_sel));
      chk($sformatf("tab%0d_out", i), o_re[0], 16'(tab[i].e_out));
      chk($sformatf("tab%0d_fs", i), 16'(fs[0]), 16'(tab[i].e_fs));
      chk($sformatf("tab%0d_dv", i), 16'(dv[0]), 16'(tab[i].e_dv));
      commit();
    end

    // mid-frame asynchronous reset after 5 samples (DEPTH=8 focus)
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 16'(i), 16'(i + 50), 16'(i + 100), 16'(i + 150), 1'b0);
    drive(1'b1, 16'd6, 16'd56, 16'd106, 16'd156, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int k = 0; k < 3; k++) n[k] = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(1'b1, 16'd7, 16'd57, 16'd107, 16'd157, 1'b0);
    chk("midrst_fs_d8", 16'(fs[1]), 16'h0001);
    chk("midrst_sel_d8", 16'(sel[1]), 16'h0000);
    commit();

    // DEPTH=1: selection alternates and output is the previous cycle's write
    do_reset();
    drive(1'b1, 16'd1, 16'd11, 16'd101, 16'd111, 1'b0);
    chk("d1_s1_sel", 16'(sel[2]), 16'h0000); chk("d1_s1_out", o_re[2], 16'd0);
    commit();
    drive(1'b1, 16'd2, 16'd12, 16'd102, 16'd112, 1'b0);
    chk("d1_s2_sel", 16'(sel[2]), 16'h0001); chk("d1_s2_out", o_re[2], 16'd1);
    commit();
    drive(1'b1, 16'd3, 16'd13, 16'd103, 16'd113, 1'b0);
    chk("d1_s3_sel", 16'(sel[2]), 16'h0000); chk("d1_s3_out", o_re[2], 16'd102);
    commit();
    drive(1'b1, 16'd4, 16'd14, 16'd104, 16'd114, 1'b0);
    chk("d1_s4_sel", 16'(sel[2]), 16'h0001); chk("d1_s4_out", o_re[2], 16'd3);
    commit();

`ifdef SDF_DELAY_CLEAR_EN
    // Clear together with Valid_In at Cnt=6 on the DEPTH=4 instance
    do_reset();
    for (int i = 1; i <= 6; i++) cyc(1'b1, 16'(i), 16'(i + 50), 16'(i + 100), 16'(i + 150), 1'b0);
    cyc(1'b1, 16'd99, 16'd98, 16'd97, 16'd96, 1'b1);
    drive(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
    chk("clr_dv_d4", 16'(dv[0]), 16'h0000);
    chk("clr_sel_d4", 16'(sel[0]), 16'h0000);
    chk("clr_out_d4", o_re[0], 16'h0000);
    commit();
    drive(1'b1, 16'd5, 16'd6, 16'd7, 16'd8, 1'b0);
    chk("clr_fs_d4", 16'(fs[0]), 16'h0001);
    commit();
`endif

    // randomized traffic with stalls and occasional resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 96) == 0) begin
        do_reset();
      end else begin
`ifdef SDF_DELAY_CLEAR_EN
        cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), $urandom_range(0, 52) == 0);
`else
        cyc($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
            16'($urandom), 1'b0);
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
